// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: bundles the signals between fifo_ctrl, its users and the FIFO RAM.
//   Request side : push, push_data, pop       (driven by producer/consumer)
//   Status side  : pop_data_vld, full, empty, almost_full, count
//   RAM side     : ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr
//   Optional     : ovf_err, udf_err (present only with FIFO_CTRL_ERR_FLAG_EN)
// Modports: master = user/environment view, slave = fifo_ctrl view.
// Macro FIFO_CTRL_ERR_FLAG_EN adds the sticky error flags.
interface fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic                  pop_data_vld;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  ram_w_en;
  logic [ADDR_WIDTH-1:0] ram_w_addr;
  logic [DATA_WIDTH-1:0] ram_w_data;
  logic                  ram_r_en;
  logic [ADDR_WIDTH-1:0] ram_r_addr;
`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic                  ovf_err;
  logic                  udf_err;

  modport master (
    output push, push_data, pop,
    input  pop_data_vld, full, empty, almost_full, count,
    input  ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr,
    input  ovf_err, udf_err
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data_vld, full, empty, almost_full, count,
    output ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr,
    output ovf_err, udf_err
  );
`else
  modport master (
    output push, push_data, pop,
    input  pop_data_vld, full, empty, almost_full, count,
    input  ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr
  );

  modport slave (
    input  push, push_data, pop,
    output pop_data_vld, full, empty, almost_full, count,
    output ram_w_en, ram_w_addr, ram_w_data, ram_r_en, ram_r_addr
  );
`endif
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: synchronous FIFO controller for a single-clock dual-port RAM with
// registered (1-cycle) read. Owns read/write pointers, occupancy count and the
// full/empty/almost_full flags, and turns push/pop requests into RAM strobes.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - fifo_ctrl_if.slave (requests, status, RAM drive)
// Optional feature: define FIFO_CTRL_ERR_FLAG_EN to add sticky ovf_err/udf_err.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_ctrl_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_CNT = (ADDR_WIDTH + 1)'(AFULL_TH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  rd_vld;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_acc;
  logic                  pop_acc;
  logic [DATA_WIDTH-1:0] wr_data;

  // Flags come only from the registered count, so push/pop never reach them.
  assign full_s  = (cnt == DEPTH_CNT);
  assign empty_s = (cnt == '0);

  assign push_acc = bus.push & ~full_s;
  assign pop_acc  = bus.pop & ~empty_s;

  assign wr_data = bus.push_data;

  // RAM strobes are gated by rst_n so nothing is written or read on a reset edge.
  assign bus.ram_w_en   = push_acc & rst_n;
  assign bus.ram_w_addr = wptr;
  assign bus.ram_w_data = wr_data;
  assign bus.ram_r_en   = pop_acc & rst_n;
  assign bus.ram_r_addr = rptr;

  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (cnt >= AFULL_CNT);
  assign bus.count        = cnt;
  assign bus.pop_data_vld = rd_vld;

  // Pointers wrap by explicit compare so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_acc) wptr <= (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
      if (pop_acc)  rptr <= (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
    end
  end

  // Occupancy: a simultaneous accepted push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Valid strobe lines up with the RAM's registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_vld <= 1'b0;
    else        rd_vld <= pop_acc;
  end

`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic ovf_q;
  logic udf_q;

  // Sticky error flags record any rejected request until the next reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.push & full_s) ovf_q <= 1'b1;
      if (bus.pop & empty_s) udf_q <= 1'b1;
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl with a behavioural
// registered-read RAM model attached to the RAM side of the interface.
module tb_fifo_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  fifo_ctrl #(
    .DATA_WIDTH(8),
    .RAM_DEPTH (16),
    .ADDR_WIDTH(4),
    .AFULL_TH  (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic [7:0] mem [16];
  logic [7:0] r_data;

  // RAM model: synchronous write, registered read.
  always @(posedge clk) begin
    if (bus.ram_w_en) mem[bus.ram_w_addr] <= bus.ram_w_data;
    if (bus.ram_r_en) r_data <= mem[bus.ram_r_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive request inputs just after the falling edge.
  task automatic applyStimulus(input logic p, input logic [7:0] d, input logic q);
    @(negedge clk);
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = q;
    #1;
  endtask

  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.push      = 1'b0;
    bus.push_data = 8'h00;
    bus.pop       = 1'b0;

    // Reset, with a push held to show RAM strobes are forced off.
    clockEdge();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkOutput("rst_w_en", 32'(bus.ram_w_en), 32'd0);
    checkOutput("rst_r_en", 32'(bus.ram_r_en), 32'd0);
    clockEdge();
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    clockEdge();
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_afull", 32'(bus.almost_full), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_vld", 32'(bus.pop_data_vld), 32'd0);
    checkOutput("idle_w_en", 32'(bus.ram_w_en), 32'd0);
    checkOutput("idle_r_en", 32'(bus.ram_r_en), 32'd0);
`ifdef FIFO_CTRL_ERR_FLAG_EN
    checkOutput("rst_ovf", 32'(bus.ovf_err), 32'd0);
    checkOutput("rst_udf", 32'(bus.udf_err), 32'd0);
`endif

    // Push 0x11..0x1C, almost_full at count 12.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'(8'h11 + i), 1'b0);
      checkOutput("p12_w_en", 32'(bus.ram_w_en), 32'd1);
      checkOutput("p12_w_addr", 32'(bus.ram_w_addr), 32'(i));
      clockEdge();
      checkOutput("p12_count", 32'(bus.count), 32'(i + 1));
      checkOutput("p12_afull", 32'(bus.almost_full), (i == 11) ? 32'd1 : 32'd0);
    end

    // Pop 12, data in order with valid one cycle after each pop.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput("q12_r_en", 32'(bus.ram_r_en), 32'd1);
      checkOutput("q12_r_addr", 32'(bus.ram_r_addr), 32'(i));
      clockEdge();
      checkOutput("q12_vld", 32'(bus.pop_data_vld), 32'd1);
      checkOutput("q12_data", 32'(r_data), 32'(8'h11 + i));
      checkOutput("q12_count", 32'(bus.count), 32'(11 - i));
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    clockEdge();
    checkOutput("q12_vld_off", 32'(bus.pop_data_vld), 32'd0);
    checkOutput("q12_empty", 32'(bus.empty), 32'd1);

    // Fill to 16 starting at address 12; 17th push rejected.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
      checkOutput("fill_w_addr", 32'(bus.ram_w_addr), 32'((12 + i) % 16));
      clockEdge();
      checkOutput("fill_count", 32'(bus.count), 32'(i + 1));
      checkOutput("fill_full", 32'(bus.full), (i == 15) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("ovf_w_en", 32'(bus.ram_w_en), 32'd0);
    clockEdge();
    checkOutput("ovf_count", 32'(bus.count), 32'd16);
    checkOutput("ovf_full", 32'(bus.full), 32'd1);
`ifdef FIFO_CTRL_ERR_FLAG_EN
    checkOutput("ovf_err", 32'(bus.ovf_err), 32'd1);
`endif

    // Push+pop while full: pop wins, push dropped.
    applyStimulus(1'b1, 8'h77, 1'b1);
    checkOutput("fpp_w_en", 32'(bus.ram_w_en), 32'd0);
    checkOutput("fpp_r_en", 32'(bus.ram_r_en), 32'd1);
    checkOutput("fpp_r_addr", 32'(bus.ram_r_addr), 32'd12);
    clockEdge();
    checkOutput("fpp_count", 32'(bus.count), 32'd15);
    checkOutput("fpp_vld", 32'(bus.pop_data_vld), 32'd1);
    checkOutput("fpp_data", 32'(r_data), 32'h20);
    checkOutput("fpp_full", 32'(bus.full), 32'd0);

    // Drain remaining 15 entries 0x21..0x2F across the wrap.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      clockEdge();
      checkOutput("drain_data", 32'(r_data), 32'(8'h21 + i));
      checkOutput("drain_count", 32'(bus.count), 32'(14 - i));
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    // Push+pop while empty: push wins, no valid strobe.
    applyStimulus(1'b1, 8'h55, 1'b1);
    checkOutput("epp_w_en", 32'(bus.ram_w_en), 32'd1);
    checkOutput("epp_r_en", 32'(bus.ram_r_en), 32'd0);
    clockEdge();
    checkOutput("epp_count", 32'(bus.count), 32'd1);
    checkOutput("epp_vld", 32'(bus.pop_data_vld), 32'd0);
`ifdef FIFO_CTRL_ERR_FLAG_EN
    checkOutput("udf_err", 32'(bus.udf_err), 32'd1);
`endif
    applyStimulus(1'b0, 8'h00, 1'b1);
    clockEdge();
    checkOutput("epp_data", 32'(r_data), 32'h55);
    checkOutput("epp_empty", 32'(bus.empty), 32'd1);

    // Steady state at occupancy 3 with simultaneous push+pop, pointers wrap.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b0);
      clockEdge();
    end
    checkOutput("wrap_pre_count", 32'(bus.count), 32'd3);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 8'(8'h63 + i), 1'b1);
      checkOutput("wrap_w_addr", 32'(bus.ram_w_addr), 32'(i % 16));
      checkOutput("wrap_r_addr", 32'(bus.ram_r_addr), 32'((13 + i) % 16));
      clockEdge();
      checkOutput("wrap_count", 32'(bus.count), 32'd3);
      checkOutput("wrap_data", 32'(r_data), 32'(8'h60 + i));
    end

    // Bring occupancy to 5, launch a pop, then reset while it is in flight.
    applyStimulus(1'b1, 8'h8B, 1'b0);
    clockEdge();
    applyStimulus(1'b1, 8'h8C, 1'b0);
    clockEdge();
    checkOutput("pre_rst_count", 32'(bus.count), 32'd5);
    applyStimulus(1'b0, 8'h00, 1'b1);
    clockEdge();
    checkOutput("pre_rst_vld", 32'(bus.pop_data_vld), 32'd1);
    checkOutput("pre_rst_data", 32'(r_data), 32'h88);
    applyStimulus(1'b1, 8'h99, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_w_en", 32'(bus.ram_w_en), 32'd0);
    checkOutput("mid_rst_r_en", 32'(bus.ram_r_en), 32'd0);
    clockEdge();
    checkOutput("mid_rst_vld", 32'(bus.pop_data_vld), 32'd0);
    checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
    checkOutput("mid_rst_empty", 32'(bus.empty), 32'd1);
`ifdef FIFO_CTRL_ERR_FLAG_EN
    checkOutput("mid_rst_ovf", 32'(bus.ovf_err), 32'd0);
    checkOutput("mid_rst_udf", 32'(bus.udf_err), 32'd0);
`endif
    applyStimulus(1'b1, 8'hA5, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_w_addr", 32'(bus.ram_w_addr), 32'd0);
    clockEdge();
    checkOutput("post_rst_count", 32'(bus.count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_r_addr", 32'(bus.ram_r_addr), 32'd0);
    clockEdge();
    checkOutput("post_rst_vld", 32'(bus.pop_data_vld), 32'd1);
    checkOutput("post_rst_data", 32'(r_data), 32'hA5);
    checkOutput("post_rst_empty", 32'(bus.empty), 32'd1);

    applyStimulus(1'b0, 8'h00, 1'b0);
    clockEdge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Synchronous FIFO controller that drives the single-clock dual-port FIFO RAM (registered read, 1-cycle latency).
- Owns the read/write pointers, occupancy count and full/empty flags.
- Converts upstream push/pop requests into RAM w_en/w_addr and r_en/r_addr.
- Provides a read-data-valid strobe aligned to RAM read data.
- Sits between the bus/UART producer and consumer logic and the FIFO RAM.

Parameters:
- DATA_WIDTH, 8, width of a FIFO entry; passed through to the RAM write data.
- RAM_DEPTH, 16, number of entries; any value from 2 to 2**ADDR_WIDTH; need not be a power of two.
- ADDR_WIDTH, 4, RAM address width.
- AFULL_TH, 12, almost_full asserts when count >= AFULL_TH; legal range 1..RAM_DEPTH.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- push  input  1  write request.
- push_data  input  DATA_WIDTH  data to write.
- pop  input  1  read request.
- pop_data_vld  output  1  RAM r_data holds popped entry this cycle.
- full  output  1  count == RAM_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- count  output  ADDR_WIDTH+1  current occupancy.
- ram_w_en  output  1  to RAM w_en.
- ram_w_addr  output  ADDR_WIDTH  to RAM w_addr.
- ram_w_data  output  DATA_WIDTH  to RAM w_data.
- ram_r_en  output  1  to RAM r_en.
- ram_r_addr  output  ADDR_WIDTH  to RAM r_addr.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears wptr, rptr, count and pop_data_vld to 0. After reset: empty=1, full=0, almost_full=0. RAM contents are not cleared.
- Reset mid-operation: an in-flight pop_data_vld is dropped. The push/pop presented on the reset edge is ignored.
- Accept rules (combinational):
  - push_acc = push & ~full.
  - pop_acc = pop & ~empty.
  - Requests that are not accepted are discarded silently; no state change.
- RAM drive (combinational):
  - ram_w_en = push_acc; ram_w_addr = wptr; ram_w_data = push_data.
  - ram_r_en = pop_acc; ram_r_addr = rptr.
  - While rst_n is low, ram_w_en and ram_r_en are forced to 0.
- Pointers:
  - On push_acc, wptr increments. On pop_acc, rptr increments.
  - Wrap from RAM_DEPTH-1 to 0 by explicit compare, not natural overflow.
- Count update per cycle:
  - +1 on push_acc only.
  - -1 on pop_acc only.
  - unchanged on both or neither.
- Flags are decoded from the registered count (no combinational path from push/pop).
- Simultaneous push and pop:
  - When full: the pop is accepted, the push is rejected (full is evaluated before the pop).
  - When empty: the push is accepted, the pop is rejected.
  - Otherwise both are accepted, count is unchanged, and wptr/rptr both advance.
- Read latency: pop_acc at edge N means pop_data_vld=1 during cycle N+1, aligned with RAM r_data. pop_data_vld is a register equal to pop_acc delayed by one cycle.
- Same-address read and write cannot occur on an accepted pair: write goes to wptr, read comes from rptr, and wptr==rptr only when empty or full.
- Back-to-back pops every cycle are supported at one entry per cycle.

Optional Feature:
- Macro FIFO_CTRL_ERR_FLAG_EN.
- When defined, two extra output ports are added:
  - ovf_err: sticky, set when push & full.
  - udf_err: sticky, set when pop & empty.
  - Both clear only on reset. Reset value is 0.
- When undefined: the ports and their logic are absent; rejected requests leave no trace.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, pop_data_vld=0, ram_w_en=ram_r_en=0.
- Push 0x11..0x1C (12 entries), then pop 12 times -> almost_full=1 at count=12. Data 0x11..0x1C returned in order, each with pop_data_vld one cycle after its pop. empty=1 at end.
- Push 17 entries -> full=1 after the 16th; 17th rejected (ram_w_en=0, count stays 16). With FIFO_CTRL_ERR_FLAG_EN, ovf_err=1.
- Wrap-around: push/pop 40 entries at occupancy ~3 with simultaneous push+pop -> wptr/rptr wrap 15->0. Count stays 3. Data order preserved.
- Full with push+pop same cycle -> pop accepted, push rejected, count=15. Empty with push+pop -> push accepted, count=1, pop_data_vld=0 next cycle. udf_err=1 if enabled.
- Assert rst_n=0 for one cycle while count=5 and a pop is in flight -> next cycle pop_data_vld=0, count=0, empty=1. Subsequent push 0xA5 then pop returns 0xA5.
